// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and the single-cycle operation evaluator for the EX-stage ALU.
// The evaluator works on 64-bit zero-extended operands, so widths up to 64 are supported.
package alu_pkg;

   localparam int MAXW = 64;

   localparam logic [3:0] OP_ADD     = 4'd0;
   localparam logic [3:0] OP_SUB     = 4'd1;
   localparam logic [3:0] OP_MUL     = 4'd2;
   localparam logic [3:0] OP_AND     = 4'd3;
   localparam logic [3:0] OP_OR      = 4'd4;
   localparam logic [3:0] OP_SLL     = 4'd5;
   localparam logic [3:0] OP_SRL     = 4'd6;
   localparam logic [3:0] OP_SLTU    = 4'd7;
   localparam logic [3:0] OP_SEQ     = 4'd8;
   localparam logic [3:0] OP_SNE     = 4'd9;
   localparam logic [3:0] OP_ABSDIFF = 4'd10;
   localparam logic [3:0] OP_SLT     = 4'd11;
   localparam logic [3:0] OP_SRA     = 4'd12;
   localparam logic [3:0] OP_XOR     = 4'd13;

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_MUL_BUSY = 1'b1
   } aluState_t;

   // Signed ops sign-extend from bit w-1; every result is masked back to w bits.
   function automatic logic [MAXW-1:0] evalOp(input logic [3:0] op,
                                              input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b,
                                              input int unsigned w);
      logic [MAXW-1:0] mask;
      logic [MAXW-1:0] shamt;
      logic [MAXW-1:0] aSx;
      logic [MAXW-1:0] bSx;
      logic [MAXW-1:0] res;
      mask  = {MAXW{1'b1}} >> (MAXW - w);
      shamt = b & MAXW'(w - 1);
      aSx   = a[w-1] ? (a | ~mask) : a;
      bSx   = b[w-1] ? (b | ~mask) : b;
      case (op)
         OP_ADD:     res = a + b;
         OP_SUB:     res = a - b;
         OP_AND:     res = a & b;
         OP_OR:      res = a | b;
         OP_SLL:     res = a << shamt;
         OP_SRL:     res = a >> shamt;
         OP_SLTU:    res = MAXW'(a < b);
         OP_SEQ:     res = MAXW'(a == b);
         OP_SNE:     res = MAXW'(a != b);
         OP_ABSDIFF: res = (a >= b) ? (a - b) : (b - a);
         OP_SLT:     res = MAXW'($signed(aSx) < $signed(bSx));
         OP_SRA:     res = $signed(aSx) >>> shamt;
         OP_XOR:     res = a ^ b;
         default:    res = '0;
      endcase
      return res & mask;
   endfunction

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first, always WIDTH steps.
// done marks the step that retires the last bit; product is the accumulator value after that step.
module alu_seq_mult #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   logic             busy;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] accNext;

   assign accNext = mplier[0] ? (acc + mcand) : acc;
   assign done    = busy && (count == CW'(WIDTH - 1));
   assign product = accNext;

   // Load on start, then shift the multiplicand up and the multiplier down each step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy   <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         count  <= '0;
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else if (busy) begin
         acc    <= accNext;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_pipe_hs.sv
// EX-stage ALU with valid/ready handshakes on both sides and a registered result.
// Single-cycle ops complete on the accept edge; MUL hands off to the shift-add engine.
module alu_pipe_hs
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             IllegalOp
);

   aluState_t        state;
   logic             accept;
   logic             startMul;
   logic             multDone;
   logic [WIDTH-1:0] multProduct;
   logic [WIDTH-1:0] opResult;

   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign startMul = accept && (ALUControl == OP_MUL);
   assign opResult = WIDTH'(evalOp(ALUControl, MAXW'(A), MAXW'(B), WIDTH));

   alu_seq_mult #(
      .WIDTH (WIDTH),
      .CW    (SHW)
   ) u_mult (
      .clock   (Clk),
      .reset   (Reset),
      .start   (startMul),
      .a       (A),
      .b       (B),
      .done    (multDone),
      .product (multProduct)
   );

   // Accepting a MUL can only happen with the output slot empty or draining, so out_valid drops.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         ALUResult <= '0;
         Zero      <= 1'b0;
         IllegalOp <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (ALUControl == OP_MUL) begin
                     state     <= S_MUL_BUSY;
                     out_valid <= 1'b0;
                  end else begin
                     ALUResult <= opResult;
                     Zero      <= (opResult == '0);
                     IllegalOp <= (ALUControl > OP_XOR);
                     out_valid <= 1'b1;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            S_MUL_BUSY: begin
               if (multDone) begin
                  ALUResult <= multProduct;
                  Zero      <= (multProduct == '0);
                  IllegalOp <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Scoreboard bench for alu_pipe_hs: the stimulus side queues reference results at accept time,
// an independent monitor pops and compares whenever a result is handed over.
module tb_alu_pipe_hs;

   localparam logic [3:0] T_ADD = 4'd0,  T_SUB = 4'd1,  T_MUL = 4'd2,  T_OR  = 4'd4;
   localparam logic [3:0] T_SLTU = 4'd7, T_ABS = 4'd10, T_SLT = 4'd11, T_SRA = 4'd12;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] res;
      logic        zero;
      logic        ill;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  ALUControl = 4'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        IllegalOp;

   int   total = 0;
   int   bad = 0;
   exp_t sbQ[$];
   exp_t monExp;
   bit   randReady = 1'b0;
   bit   readyForce = 1'b1;

   alu_pipe_hs #(.WIDTH(32)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUControl (ALUControl),
      .A          (A),
      .B          (B),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .IllegalOp  (IllegalOp)
   );

   always #5 Clk = ~Clk;

   // Plain-arithmetic reference: full 64-bit product, modulo shift amounts, signed casts.
   function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      logic [63:0] prod;
      sh   = b % 32;
      prod = 64'(a) * 64'(b);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return prod[31:0];
         4'd3:  return a & b;
         4'd4:  return a | b;
         4'd5:  return a << sh;
         4'd6:  return a >> sh;
         4'd7:  return (a < b) ? 32'd1 : 32'd0;
         4'd8:  return (a == b) ? 32'd1 : 32'd0;
         4'd9:  return (a != b) ? 32'd1 : 32'd0;
         4'd10: return (a >= b) ? (a - b) : (b - a);
         4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12: return 32'($signed(a) >>> sh);
         4'd13: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%h want=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic failNow(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accept edge.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   waited = 0;
      bit   done = 1'b0;
      in_valid = 1'b1;
      ALUControl = op;
      A = a;
      B = b;
      while (!done) begin
         @(negedge Clk);
         if (in_ready) begin
            e.op   = op;
            e.res  = refModel(op, a, b);
            e.zero = (e.res == 32'd0);
            e.ill  = (op >= 4'd14);
            sbQ.push_back(e);
            done = 1'b1;
         end else if (waited >= 200) begin
            failNow("accept_timeout");
            done = 1'b1;
         end
         waited++;
         @(posedge Clk);
         #1;
      end
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
      ALUControl = 4'($urandom_range(0, 15));
   endtask

   task automatic waitDrain(input int bound);
      int n = 0;
      while ((sbQ.size() != 0 || out_valid) && n < bound) begin
         @(posedge Clk);
         #1;
         n++;
      end
      if (n >= bound) failNow("drain_timeout");
   endtask

   function automatic logic [31:0] pickVal();
      logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   // Consumer side: forced level in directed phases, random back-pressure in the random phase.
   always @(posedge Clk) begin
      #2;
      out_ready = randReady ? ($urandom_range(0, 3) != 0) : readyForce;
   end

   // Monitor: every handed-over result must match the oldest queued expectation.
   always @(negedge Clk) begin
      if (!Reset && out_valid && out_ready) begin
         if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_result: got=%h want=none at %0t", ALUResult, $time);
         end else begin
            monExp = sbQ.pop_front();
            checkOutput($sformatf("result_op%0d", monExp.op), ALUResult, monExp.res);
            checkOutput($sformatf("zero_op%0d", monExp.op), 32'(Zero), 32'(monExp.zero));
            checkOutput($sformatf("illegal_op%0d", monExp.op), 32'(IllegalOp), 32'(monExp.ill));
         end
      end
   end

   initial begin
      int cycles;
      int readyHigh;
      logic [3:0] op;

      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      #1;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_result", ALUResult, 32'd0);
      checkOutput("reset_zero", 32'(Zero), 32'd0);
      checkOutput("reset_illegal", 32'(IllegalOp), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge Clk);
      #1;

      $display("[TB] directed ops");
      applyStimulus(T_ADD, 32'hFFFF_FFFF, 32'h1);
      checkOutput("add_latency_valid", 32'(out_valid), 32'd1);
      applyStimulus(T_SUB, 32'd5, 32'd7);

      applyStimulus(T_MUL, 32'h0001_2345, 32'h0000_0100);
      cycles = 0;
      readyHigh = 0;
      while (!out_valid && cycles < 100) begin
         if (in_ready) readyHigh++;
         @(posedge Clk);
         #1;
         cycles++;
      end
      checkOutput("mul_latency", 32'(cycles), 32'd32);
      checkOutput("mul_in_ready_low", 32'(readyHigh), 32'd0);
      applyStimulus(T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus(T_MUL, 32'h0, 32'h1234_5678);
      applyStimulus(T_SLT, 32'h8000_0000, 32'h1);
      applyStimulus(T_SLTU, 32'h8000_0000, 32'h1);
      applyStimulus(T_SRA, 32'h8000_0000, 32'h21);
      applyStimulus(T_ABS, 32'd3, 32'd10);
      applyStimulus(4'd14, 32'h1234, 32'h5678);
      applyStimulus(4'd15, 32'h0, 32'h0);
      applyStimulus(T_ADD, 32'd1, 32'd1);
      waitDrain(200);

      $display("[TB] back-pressure");
      readyForce = 1'b0;
      applyStimulus(T_ADD, 32'd3, 32'd4);
      repeat (5) begin
         @(negedge Clk);
         checkOutput("hold_result", ALUResult, 32'd7);
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge Clk);
      #1;
      readyForce = 1'b1;
      applyStimulus(T_OR, 32'hF0, 32'h0F);
      checkOutput("no_bubble_valid", 32'(out_valid), 32'd1);
      checkOutput("no_bubble_result", ALUResult, 32'hFF);
      waitDrain(200);

      $display("[TB] reset during multiply");
      applyStimulus(T_ADD, 32'h55, 32'h22);
      applyStimulus(T_MUL, 32'hDEAD_BEEF, 32'h0000_1357);
      repeat (9) @(posedge Clk);
      #1;
      Reset = 1'b1;
      sbQ.delete();
      #1;
      checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      #1;
      checkOutput("post_reset_valid", 32'(out_valid), 32'd0);
      checkOutput("post_reset_result", ALUResult, 32'd0);
      checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
      repeat (40) @(posedge Clk);
      #1;
      checkOutput("no_stale_result", 32'(out_valid), 32'd0);

      $display("[TB] random traffic");
      randReady = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == T_MUL && $urandom_range(0, 3) != 0) op = T_ADD;
         applyStimulus(op, pickVal(), pickVal());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge Clk);
            #1;
         end
      end
      randReady = 1'b0;
      readyForce = 1'b1;
      @(posedge Clk);
      #1;
      waitDrain(3000);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
